// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the buffered UART transmitter: rate defaults,
// divider computation, FSM encoding and the I/O-decode data address.
package uart_tx_fifo_pkg;

  localparam int DEFAULT_CLOCK_RATE = 12_000_000;
  localparam int DEFAULT_BAUD_RATE  = 115_200;
  localparam int DEFAULT_FIFO_LOG2  = 3;

  // Address the memory-mapped decode maps onto a push of this block.
  localparam logic [31:0] UART_DATA_ADDR = 32'h0200_0000;

  // Transmitter states; encoding is fixed so firmware-visible debug taps stay stable.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  // Clock cycles per bit, truncated toward zero.
  function automatic int calc_div(input int clock_rate, input int baud_rate);
    return clock_rate / baud_rate;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_byte_fifo.sv
// Synchronous byte FIFO with first-word-fall-through read port: dout always
// shows the head entry so the consumer can pop and use it in one cycle.
module byte_fifo #(
  parameter int WIDTH = 8,
  parameter int LOG2  = 3
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [LOG2:0]    level
);

  localparam int DEPTH = 1 << LOG2;
  localparam logic [LOG2-1:0] PTR_ONE = 1;
  localparam logic [LOG2:0]   LVL_ONE = 1;
  localparam logic [LOG2:0]   LVL_MAX = (LOG2 + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [LOG2-1:0]  r_wr_ptr;
  logic [LOG2-1:0]  r_rd_ptr;
  logic [LOG2:0]    r_level;
  logic             w_wr_en;
  logic             w_rd_en;

  // Status comes from the registered level, so a push while full is dropped
  // even if a pop happens on the same edge.
  assign full    = (r_level == LVL_MAX);
  assign empty   = (r_level == '0);
  assign level   = r_level;
  assign w_wr_en = push & ~full;
  assign w_rd_en = pop & ~empty;
  assign dout    = r_mem[r_rd_ptr];

  // Storage array; contents are only meaningful below the level, so no reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointers wrap modulo depth; level tracks occupancy (unchanged on push+pop).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_rd_en) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_wr_en, w_rd_en})
        2'b10:   r_level <= r_level + LVL_ONE;
        2'b01:   r_level <= r_level - LVL_ONE;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter. Bytes pushed by the I/O decode are queued in
// byte_fifo and serialised LSB first; back-to-back frames have no idle gap.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int CLOCK_RATE = DEFAULT_CLOCK_RATE,
  parameter int BAUD_RATE  = DEFAULT_BAUD_RATE,
  parameter int FIFO_LOG2  = DEFAULT_FIFO_LOG2
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               push,
  input  logic [7:0]         push_data,
  output logic               full,
  output logic               empty,
  output logic               busy,
  output logic [FIFO_LOG2:0] level,
  output logic               uart_tx
);

  localparam int DIV   = calc_div(CLOCK_RATE, BAUD_RATE);
  localparam int CNT_W = (DIV < 2) ? 1 : $clog2(DIV);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] BAUD_ONE  = 1;

  generate
    if (DIV < 2) begin : g_bad_div
      $error("uart_tx_fifo: CLOCK_RATE/BAUD_RATE must be at least 2");
    end
  endgenerate

  uart_state_t      r_state;
  logic [CNT_W-1:0] r_baud_cnt;
  logic [2:0]       r_bit_cnt;
  logic [7:0]       r_shift;
  logic             r_tx;

  logic             w_baud_end;
  logic             w_pop;
  logic [7:0]       w_head;
  logic             w_full;
  logic             w_empty;
  logic [FIFO_LOG2:0] w_level;

  byte_fifo #(
    .WIDTH (8),
    .LOG2  (FIFO_LOG2)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .pop   (w_pop),
    .din   (push_data),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .level (w_level)
  );

  // A frame begins either from idle or straight out of a finishing stop bit.
  assign w_baud_end = (r_baud_cnt == BAUD_LAST);
  assign w_pop      = ~w_empty & ((r_state == IDLE) | ((r_state == STOP) & w_baud_end));

  assign full    = w_full;
  assign empty   = w_empty;
  assign level   = w_level;
  assign busy    = (r_state != IDLE) | ~w_empty;
  assign uart_tx = r_tx;

  // Shift register: load the head byte on pop, move right after each data bit.
  always_ff @(posedge clk) begin
    if (w_pop) begin
      r_shift <= w_head;
    end else if ((r_state == DATA) && w_baud_end) begin
      r_shift <= {1'b0, r_shift[7:1]};
    end
  end

  // Frame sequencer with baud and bit counters; the line level is registered here.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= IDLE;
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_tx       <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          r_baud_cnt <= '0;
          r_tx       <= 1'b1;
          if (!w_empty) begin
            r_tx    <= 1'b0;
            r_state <= START;
          end
        end
        START: begin
          if (w_baud_end) begin
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_tx       <= r_shift[0];
            r_state    <= DATA;
          end else begin
            r_baud_cnt <= r_baud_cnt + BAUD_ONE;
          end
        end
        DATA: begin
          if (w_baud_end) begin
            r_baud_cnt <= '0;
            if (r_bit_cnt == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= STOP;
            end else begin
              // r_shift[1] becomes shift[0] on this same edge.
              r_bit_cnt <= r_bit_cnt + 3'd1;
              r_tx      <= r_shift[1];
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + BAUD_ONE;
          end
        end
        STOP: begin
          if (w_baud_end) begin
            r_baud_cnt <= '0;
            if (!w_empty) begin
              r_tx    <= 1'b0;
              r_state <= START;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + BAUD_ONE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a cycle-level reference built from frame timing
// arithmetic and a byte queue, plus directed sequences and a vector table.
module tb_uart_tx_fifo;

  localparam int DIV    = 16;
  localparam int DEPTH  = 8;
  localparam int DIV_D  = 104;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic       push = 1'b0;
  logic [7:0] push_data = 8'h00;
  logic       full, empty, busy, uart_tx;
  logic [3:0] level;

  logic       push_d = 1'b0;
  logic [7:0] data_d = 8'h00;
  logic       full_d, empty_d, busy_d, tx_d;
  logic [3:0] level_d;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [7:0] mq[$];
  int         m_edge = 0;
  int         m_start = 0;
  bit         m_active = 0;
  logic [7:0] m_cur = 8'h00;
  logic       exp_tx = 1'b1;
  logic       exp_busy = 1'b0;
  int         exp_level = 0;

  typedef struct {
    logic       p;
    logic [7:0] d;
    int         lvl;
    logic       f;
    logic       e;
  } vec_t;

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .CLOCK_RATE (16),
    .BAUD_RATE  (1),
    .FIFO_LOG2  (3)
  ) u_dut (
    .clk       (clk),
    .rstn      (rstn),
    .push      (push),
    .push_data (push_data),
    .full      (full),
    .empty     (empty),
    .busy      (busy),
    .level     (level),
    .uart_tx   (uart_tx)
  );

  uart_tx_fifo u_dut_def (
    .clk       (clk),
    .rstn      (rstn),
    .push      (push_d),
    .push_data (data_d),
    .full      (full_d),
    .empty     (empty_d),
    .busy      (busy_d),
    .level     (level_d),
    .uart_tx   (tx_d)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock edge of the reference: transmitter is free once 10*DIV edges of
  // a frame have passed; it then takes the oldest queued byte (pre-edge view).
  task automatic model_step();
    int pre_n;
    bit free_tx;
    int idx;
    if (!rstn) begin
      mq.delete();
      m_active = 0;
    end else begin
      m_edge++;
      free_tx = !m_active || ((m_edge - m_start) >= 10 * DIV);
      pre_n = mq.size();
      if (push && pre_n < DEPTH) mq.push_back(push_data);
      if (free_tx && pre_n > 0) begin
        m_cur    = mq.pop_front();
        m_start  = m_edge;
        m_active = 1;
      end else if (free_tx) begin
        m_active = 0;
      end
    end
    if (m_active && (m_edge - m_start) < 10 * DIV) begin
      idx      = (m_edge - m_start) / DIV;
      exp_tx   = (idx == 0) ? 1'b0 : (idx == 9) ? 1'b1 : m_cur[idx-1];
      exp_busy = 1'b1;
    end else begin
      exp_tx   = 1'b1;
      exp_busy = (mq.size() > 0);
    end
    exp_level = mq.size();
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("tx", uart_tx, exp_tx);
    chk("busy", busy, exp_busy);
    chk("level", level, exp_level);
    chk("full", full, exp_level == DEPTH);
    chk("empty", empty, exp_level == 0);
  endtask

  task automatic wait_idle(input int budget, input string name, output int n);
    n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    chk({name, "_idle_timeout"}, busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected end before 2000000");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       tab[10];
    logic [9:0] fr;
    int         n;
    int         rate;

    // fill-test vectors: one push per cycle from idle, first byte popped on the 2nd edge
    tab[0] = '{1'b1, 8'h00, 1, 1'b0, 1'b0};
    tab[1] = '{1'b1, 8'h01, 1, 1'b0, 1'b0};
    tab[2] = '{1'b1, 8'h02, 2, 1'b0, 1'b0};
    tab[3] = '{1'b1, 8'h03, 3, 1'b0, 1'b0};
    tab[4] = '{1'b1, 8'h04, 4, 1'b0, 1'b0};
    tab[5] = '{1'b1, 8'h05, 5, 1'b0, 1'b0};
    tab[6] = '{1'b1, 8'h06, 6, 1'b0, 1'b0};
    tab[7] = '{1'b1, 8'h07, 7, 1'b0, 1'b0};
    tab[8] = '{1'b1, 8'h08, 8, 1'b1, 1'b0};
    tab[9] = '{1'b1, 8'h09, 8, 1'b1, 1'b0};

    // asynchronous reset takes effect before any clock edge
    #1 rstn = 1'b0;
    #2;
    chk("rst_tx", uart_tx, 1);
    chk("rst_full", full, 0);
    chk("rst_empty", empty, 1);
    chk("rst_busy", busy, 0);
    chk("rst_level", level, 0);
    chk("rst_def_tx", tx_d, 1);
    chk("rst_def_busy", busy_d, 0);
    repeat (3) tick();
    rstn = 1'b1;
    repeat (2) tick();

    // single byte 0x55 from idle
    push = 1'b1; push_data = 8'h55;
    tick();
    push = 1'b0;
    chk("sb_tx_pre", uart_tx, 1);
    fr = {1'b1, 8'h55, 1'b0};
    for (int i = 0; i < 10 * DIV; i++) begin
      tick();
      chk("sb_tx_bit", uart_tx, fr[i / DIV]);
      chk("sb_busy", busy, 1);
    end
    tick();
    chk("sb_tx_end", uart_tx, 1);
    chk("sb_busy_end", busy, 0);
    repeat (3) tick();

    // fill past full from the table, then drain 9 back-to-back frames
    for (int i = 0; i < 10; i++) begin
      push = tab[i].p; push_data = tab[i].d;
      tick();
      chk("fill_level", level, tab[i].lvl);
      chk("fill_full", full, tab[i].f);
      chk("fill_empty", empty, tab[i].e);
    end
    push = 1'b0;
    wait_idle(3000, "fill", n);
    chk("fill_drain_cycles", n, 9 * 10 * DIV - 8);
    repeat (3) tick();

    // push on the edge a stop bit ends while three bytes are queued
    push = 1'b1;
    push_data = 8'h3C; tick();
    push_data = 8'hC3; tick();
    push_data = 8'h81; tick();
    push_data = 8'h7E; tick();
    push = 1'b0;
    repeat (10 * DIV - 3) tick();
    chk("pp_level_pre", level, 3);
    chk("pp_tx_stop", uart_tx, 1);
    push = 1'b1; push_data = 8'hE7;
    tick();
    push = 1'b0;
    chk("pp_level", level, 3);
    chk("pp_tx_nogap", uart_tx, 0);
    wait_idle(3000, "pp", n);
    chk("pp_drain_cycles", n, 4 * 10 * DIV);
    repeat (3) tick();

    // reset between edges during data bit 4 of 0xA5
    push = 1'b1; push_data = 8'hA5;
    tick();
    push = 1'b0;
    repeat (86) tick();
    chk("mr_tx_pre", uart_tx, 0);
    #2 rstn = 1'b0;
    #1;
    chk("mr_tx", uart_tx, 1);
    chk("mr_level", level, 0);
    chk("mr_busy", busy, 0);
    chk("mr_empty", empty, 1);
    chk("mr_full", full, 0);
    repeat (2) tick();
    rstn = 1'b1;
    repeat (12 * DIV) tick();
    chk("mr_post_tx", uart_tx, 1);
    chk("mr_post_busy", busy, 0);

    // randomized traffic at several push densities, including bursts that overflow
    for (int ph = 0; ph < 4; ph++) begin
      rate = (ph == 0) ? 40 : (ph == 1) ? 6 : (ph == 2) ? 2 : 25;
      repeat (1000) begin
        push      = ($urandom_range(0, rate - 1) == 0);
        push_data = 8'($urandom);
        tick();
      end
    end
    push = 1'b0;
    wait_idle(2000, "rnd", n);
    repeat (3) tick();

    // default rates: DIV = 104, byte 0x0D
    push_d = 1'b1; data_d = 8'h0D;
    tick();
    push_d = 1'b0;
    chk("def_tx_pre", tx_d, 1);
    fr = {1'b1, 8'h0D, 1'b0};
    for (int i = 0; i < 10 * DIV_D; i++) begin
      tick();
      chk("def_tx_bit", tx_d, fr[i / DIV_D]);
      chk("def_busy", busy_d, 1);
    end
    tick();
    chk("def_tx_end", tx_d, 1);
    chk("def_busy_end", busy_d, 0);
    chk("def_level_end", level_d, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
